m65c02_shift_seq: RTL
=====================

// Module: m65c02_shift_seq
// PURPOSE
//  Multi-count shift/rotate sequencer for the 1-bit M65C02 shift unit (SU).
//  Drives the SU one bit per clock for Cnt steps and feeds each result back as
//  the next operand. Returns the final byte, carry and overflow with a
//  Start/Busy/Done handshake.
//  Sits beside the ALU and serves extended multi-bit ASL/LSR/ROL/ROR opcodes.
// PARAMETERS
//  CNT_W   4   width of the shift count; maximum count is 2**CNT_W-1
// PORTS
//  Clk     in   1       system clock; all state changes on the rising edge
//  Rst     in   1       synchronous, active-high reset
//  Start   in   1       request; sampled only in IDLE
//  Op      in   1       0 = left (ASL/ROL), 1 = right (LSR/ROR)
//  Rot     in   1       1 = rotate through carry, 0 = shift in zero
//  Asr     in   1       arithmetic right shift (used only with the ASR option)
//  A       in   8       operand
//  Ci      in   1       initial carry
//  Cnt     in   CNT_W   number of 1-bit steps
//  Busy    out  1       high in SHIFT and DONE
//  Done    out  1       one-cycle completion strobe
//  Out     out  8       result (working register W)
//  Co      out  1       result carry (register C)
//  OV      out  1       sticky overflow
//  SU_En   out  1       SU enable
//  SU_Op   out  1       SU direction
//  SU_D    out  8       SU operand
//  SU_Ci   out  1       SU carry in
//  SU_Out  in   9       SU result {carry, byte}
//  SU_OV   in   1       SU overflow
// BEHAVIOUR
//  Reset: state=IDLE; W, C, OV, step counter N, Busy, Done all 0;
//   SU_En/SU_Op/SU_D/SU_Ci = 0.
//  States: IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE, Start=1 at an edge:
//   - load W<=A, C<=Ci, N<=Cnt, OV<=0; latch Op, Rot and Asr.
//   - go to DONE if Cnt==0, else go to SHIFT.
//  SHIFT, each cycle:
//   - SU_En=1, SU_Op=Op, SU_D=W, SU_Ci=step_ci.
//   - at the edge: W<=SU_Out[7:0], C<=SU_Out[8], N<=N-1.
//   - OV<=OV|(SU_OV&~Op), so OV only accumulates for left shifts.
//   - if N==1, go to DONE.
//  step_ci = Rot ? C : 0 (modified by the ASR option, see CONFIGURATION).
//  DONE: Done=1 for exactly one cycle, then IDLE.
//  Outputs outside SHIFT: SU_En=0 and all SU_* outputs 0.
//  Out, Co and OV hold their values from DONE until the next accepted Start.
//  Latency: Done is high in the cycle after edge Cnt+1, counting the Start
//   sampling edge as edge 1. Throughput: one operation per Cnt+2 clocks.
//  Start while Busy is ignored and not queued.
//  Operands are latched at Start; A, Ci and Cnt may change while Busy.
//  A rotate with Rot=1 and Cnt=9 returns the original {C,W}. A count of 9 or
//   more has no special handling; every step executes.
//  Rst mid-operation: next cycle matches the reset state and no Done is
//   produced. Rst overrides Start in the same cycle.
// CONFIGURATION
//  M65C02_SHIFT_ASR_EN defined:
//   - if Op=1 and Asr=1, step_ci=W[7] (sign fill) and Rot is ignored.
//   - Co is the last bit shifted out.
//  M65C02_SHIFT_ASR_EN undefined:
//   - Asr is ignored; the input exists but has no logic behind it.
//   - step_ci = Rot ? C : 0 in all cases.
// TESTING
//  1 ASL A=81 Ci=1 Rot=0 Op=0 Cnt=1 -> Done after 2 clk; Out=02 Co=1 OV=1.
//  2 ROR A=01 Ci=0 Rot=1 Op=1 Cnt=9 -> Done after 10 clk; Out=01 Co=0 OV=0;
//    SU_En high exactly 9 cycles.
//  3 Cnt=0 A=5A Ci=1 -> Done after 1 clk; Out=5A Co=1 OV=0; SU_En never high.
//  4 LSR A=F0 Rot=0 Op=1 Cnt=4 -> Out=0F Co=0 OV=0; a second Start while
//    Busy is ignored.
//  5 Cnt=8 op, Rst in step 2 -> next clk Busy=0 Done=0 Out=00 SU_En=0;
//    a following Start completes normally.
//  6 A=80 Op=1 Asr=1 Rot=0 Cnt=3 -> Out=F0 Co=0 with M65C02_SHIFT_ASR_EN;
//    Out=10 Co=0 without it.

Source files
------------

// File: rtl/m65c02_shift_seq.sv
// Multi-count shift/rotate sequencer around the external 1-bit M65C02 shift unit.
// Optional sign-fill right shift is enabled with `define M65C02_SHIFT_ASR_EN.
module m65c02_shift_seq #(
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Op,
  input  logic             Rot,
  input  logic             Asr,
  input  logic [7:0]       A,
  input  logic             Ci,
  input  logic [CNT_W-1:0] Cnt,
  output logic             Busy,
  output logic             Done,
  output logic [7:0]       Out,
  output logic             Co,
  output logic             OV,
  output logic             SU_En,
  output logic             SU_Op,
  output logic [7:0]       SU_D,
  output logic             SU_Ci,
  input  logic [8:0]       SU_Out,
  input  logic             SU_OV
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [7:0]       w_reg;
  logic             c_reg;
  logic             ov_reg;
  logic [CNT_W-1:0] n_reg;
  logic             op_reg;
  logic             rot_reg;
  logic             step_ci;

`ifdef M65C02_SHIFT_ASR_EN
  logic asr_reg;

  // Arithmetic right shift replicates the sign bit and overrides rotate.
  assign step_ci = (op_reg && asr_reg) ? w_reg[7] : (rot_reg ? c_reg : 1'b0);
`else
  logic unused_asr;

  assign unused_asr = Asr;
  assign step_ci    = rot_reg ? c_reg : 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    SU_En      = 1'b0;
    SU_Op      = 1'b0;
    SU_D       = 8'h00;
    SU_Ci      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (Start) state_next = (Cnt == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        SU_En = 1'b1;
        SU_Op = op_reg;
        SU_D  = w_reg;
        SU_Ci = step_ci;
        if (n_reg == CNT_W'(1)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Working registers: loaded at an accepted Start, stepped from the SU result.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      w_reg   <= 8'h00;
      c_reg   <= 1'b0;
      ov_reg  <= 1'b0;
      n_reg   <= '0;
      op_reg  <= 1'b0;
      rot_reg <= 1'b0;
`ifdef M65C02_SHIFT_ASR_EN
      asr_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (Start) begin
            w_reg   <= A;
            c_reg   <= Ci;
            n_reg   <= Cnt;
            ov_reg  <= 1'b0;
            op_reg  <= Op;
            rot_reg <= Rot;
`ifdef M65C02_SHIFT_ASR_EN
            asr_reg <= Asr;
`endif
          end
        end
        SHIFT: begin
          w_reg  <= SU_Out[7:0];
          c_reg  <= SU_Out[8];
          n_reg  <= n_reg - CNT_W'(1);
          // Overflow is meaningful only for left shifts.
          ov_reg <= ov_reg | (SU_OV & ~op_reg);
        end
        default: ;
      endcase
    end
  end

  assign Busy = (state_reg != IDLE);
  assign Done = (state_reg == DONE);
  assign Out  = w_reg;
  assign Co   = c_reg;
  assign OV   = ov_reg;

endmodule
